// File: rtl/alu_issue_pkg.sv
// Shared types and constants for the ALU issue/write-back stage.
// Flag vectors are ordered {Z,C,N,O}, with Z in the most significant bit.
package alu_issue_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXEC,
        ST_RES,
        ST_FLAG,
        ST_RESP
    } state_t;

    localparam logic [4:0] FS_ADD32   = 5'b10100;
    localparam logic [4:0] FS_SUB16   = 5'b00110;
    localparam logic [4:0] FS_PASSA32 = 5'b10000;

    localparam int FLAG_Z = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_O = 0;
    localparam int FLAGS_W = FLAG_Z + 1;

    function automatic logic [FLAGS_W-1:0] pack_flags(input logic z, input logic c,
                                                      input logic n, input logic o);
        logic [FLAGS_W-1:0] f;
        f         = '0;
        f[FLAG_Z] = z;
        f[FLAG_C] = c;
        f[FLAG_N] = n;
        f[FLAG_O] = o;
        return f;
    endfunction

endpackage

// File: rtl/alu_issue_regfile.sv
// General-purpose register file: two operand read ports, one debug read port,
// and a single write port shared by write-back (priority) and direct loads.
module alu_issue_regfile #(
    parameter int NREG  = 8,
    parameter int IDX_W = $clog2(NREG)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_wb_en,
    input  logic [IDX_W-1:0] i_wb_idx,
    input  logic [31:0]      i_wb_data,
    input  logic             i_ld_en,
    input  logic [IDX_W-1:0] i_ld_idx,
    input  logic [31:0]      i_ld_data,
    input  logic [IDX_W-1:0] i_rd_a_idx,
    output logic [31:0]      o_rd_a_data,
    input  logic [IDX_W-1:0] i_rd_b_idx,
    output logic [31:0]      o_rd_b_data,
    input  logic [IDX_W-1:0] i_dbg_idx,
    output logic [31:0]      o_dbg_data
);

    logic [31:0]     r_regs [NREG];
    logic [NREG-1:0] w_wr_en;
    logic [31:0]     w_wr_data;

    // Write-back wins the shared data path; the issue FSM never overlaps the two.
    assign w_wr_data = i_wb_en ? i_wb_data : i_ld_data;

    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_wr_en
            assign w_wr_en[gi] = (i_wb_en && (i_wb_idx == IDX_W'(gi))) ||
                                 (i_ld_en && (i_ld_idx == IDX_W'(gi)));
        end
    endgenerate

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (w_wr_en[i]) begin
                    r_regs[i] <= w_wr_data;
                end
            end
        end
    end

    assign o_rd_a_data = r_regs[i_rd_a_idx];
    assign o_rd_b_data = r_regs[i_rd_b_idx];
    assign o_dbg_data  = r_regs[i_dbg_idx];

endmodule

// File: rtl/alu_issue_unit.sv
// Issue/write-back stage for the registered 32-bit ALU: latches operands,
// waits out the ALU result and flag latency, writes back and responds.
module alu_issue_unit
    import alu_issue_pkg::*;
#(
    parameter int NREG  = 8,
    parameter int IDX_W = $clog2(NREG)
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_req_valid,
    output logic               o_req_ready,
    input  logic [4:0]         i_req_fun_sel,
    input  logic [IDX_W-1:0]   i_req_src_a,
    input  logic [IDX_W-1:0]   i_req_src_b,
    input  logic [IDX_W-1:0]   i_req_dst,
    input  logic               i_req_wf,
    input  logic               i_load_en,
    input  logic [IDX_W-1:0]   i_load_idx,
    input  logic [31:0]        i_load_data,
    output logic [31:0]        o_alu_a,
    output logic [31:0]        o_alu_b,
    output logic [4:0]         o_alu_fun_sel,
    output logic               o_alu_wf,
    input  logic [31:0]        i_alu_out,
    input  logic [FLAGS_W-1:0] i_alu_flags,
    output logic               o_rsp_valid,
    input  logic               i_rsp_ready,
    output logic [31:0]        o_rsp_data,
    output logic [FLAGS_W-1:0] o_rsp_flags,
    output logic [FLAGS_W-1:0] o_status_flags,
    input  logic [IDX_W-1:0]   i_dbg_idx,
    output logic [31:0]        o_dbg_data
);

    state_t               r_state;
    logic [31:0]          r_alu_a;
    logic [31:0]          r_alu_b;
    logic [4:0]           r_fun_sel;
    logic                 r_alu_wf;
    logic [IDX_W-1:0]     r_dst;
    logic [31:0]          r_rsp_data;
    logic [FLAGS_W-1:0]   r_rsp_flags;
    logic [FLAGS_W-1:0]   r_status;
    logic                 r_rsp_valid;

    logic                 w_idle;
    logic                 w_wb_en;
    logic                 w_ld_en;
    logic [31:0]          w_rd_a;
    logic [31:0]          w_rd_b;

    assign w_idle  = (r_state == ST_IDLE);
    assign w_wb_en = (r_state == ST_FLAG);
    assign w_ld_en = i_load_en && w_idle;

    alu_issue_regfile #(
        .NREG  (NREG),
        .IDX_W (IDX_W)
    ) u_regfile (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_wb_en     (w_wb_en),
        .i_wb_idx    (r_dst),
        .i_wb_data   (r_rsp_data),
        .i_ld_en     (w_ld_en),
        .i_ld_idx    (i_load_idx),
        .i_ld_data   (i_load_data),
        .i_rd_a_idx  (i_req_src_a),
        .o_rd_a_data (w_rd_a),
        .i_rd_b_idx  (i_req_src_b),
        .o_rd_b_data (w_rd_b),
        .i_dbg_idx   (i_dbg_idx),
        .o_dbg_data  (o_dbg_data)
    );

    // Operands are read combinationally at acceptance, so a same-cycle load
    // is not forwarded: the request sees the register's previous value.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_fun_sel   <= FS_PASSA32;
            r_alu_wf    <= 1'b0;
            r_dst       <= '0;
            r_rsp_data  <= '0;
            r_rsp_flags <= '0;
            r_status    <= '0;
            r_rsp_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_req_valid) begin
                        r_alu_a   <= w_rd_a;
                        r_alu_b   <= w_rd_b;
                        r_fun_sel <= i_req_fun_sel;
                        r_alu_wf  <= i_req_wf;
                        r_dst     <= i_req_dst;
                        r_state   <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    r_state <= ST_RES;
                end
                ST_RES: begin
                    r_rsp_data <= i_alu_out;
                    r_state    <= ST_FLAG;
                end
                // Flags trail the result by one edge inside the ALU.
                ST_FLAG: begin
                    r_rsp_flags <= i_alu_flags;
                    if (r_alu_wf) begin
                        r_status <= i_alu_flags;
                    end
                    r_rsp_valid <= 1'b1;
                    r_state     <= ST_RESP;
                end
                ST_RESP: begin
                    if (i_rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_rsp_valid <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_req_ready    = w_idle;
    assign o_alu_a        = r_alu_a;
    assign o_alu_b        = r_alu_b;
    assign o_alu_fun_sel  = r_fun_sel;
    assign o_alu_wf       = r_alu_wf;
    assign o_rsp_valid    = r_rsp_valid;
    assign o_rsp_data     = r_rsp_data;
    assign o_rsp_flags    = r_rsp_flags;
    assign o_status_flags = r_status;

endmodule

// File: tb/tb_alu_issue_unit.sv
// Directed bench for alu_issue_unit with a small registered ALU model
// (result one edge after operands, flags one edge after the result).
module tb_alu_issue_unit;
    import alu_issue_pkg::*;

    localparam int NREG  = 8;
    localparam int IDX_W = 3;

    logic               clk;
    logic               rst_n;
    logic               req_valid;
    logic               req_ready;
    logic [4:0]         req_fun_sel;
    logic [IDX_W-1:0]   req_src_a;
    logic [IDX_W-1:0]   req_src_b;
    logic [IDX_W-1:0]   req_dst;
    logic               req_wf;
    logic               load_en;
    logic [IDX_W-1:0]   load_idx;
    logic [31:0]        load_data;
    logic [31:0]        alu_a;
    logic [31:0]        alu_b;
    logic [4:0]         alu_fun_sel;
    logic               alu_wf;
    logic [31:0]        alu_out;
    logic [FLAGS_W-1:0] alu_flags;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [31:0]        rsp_data;
    logic [FLAGS_W-1:0] rsp_flags;
    logic [FLAGS_W-1:0] status_flags;
    logic [IDX_W-1:0]   dbg_idx;
    logic [31:0]        dbg_data;

    int errors = 0;
    int checks = 0;

    alu_issue_unit #(.NREG(NREG), .IDX_W(IDX_W)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_req_valid    (req_valid),
        .o_req_ready    (req_ready),
        .i_req_fun_sel  (req_fun_sel),
        .i_req_src_a    (req_src_a),
        .i_req_src_b    (req_src_b),
        .i_req_dst      (req_dst),
        .i_req_wf       (req_wf),
        .i_load_en      (load_en),
        .i_load_idx     (load_idx),
        .i_load_data    (load_data),
        .o_alu_a        (alu_a),
        .o_alu_b        (alu_b),
        .o_alu_fun_sel  (alu_fun_sel),
        .o_alu_wf       (alu_wf),
        .i_alu_out      (alu_out),
        .i_alu_flags    (alu_flags),
        .o_rsp_valid    (rsp_valid),
        .i_rsp_ready    (rsp_ready),
        .o_rsp_data     (rsp_data),
        .o_rsp_flags    (rsp_flags),
        .o_status_flags (status_flags),
        .i_dbg_idx      (dbg_idx),
        .o_dbg_data     (dbg_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Registered ALU model
    logic [FLAGS_W-1:0] alu_flags_pend;
    logic [31:0]        m_res;
    logic [FLAGS_W-1:0] m_flg;

    always_comb begin
        logic [32:0] s33;
        logic [16:0] s17;
        m_res = 32'hDEADBEEF;
        m_flg = '0;
        s33   = '0;
        s17   = '0;
        case (alu_fun_sel)
            FS_ADD32: begin
                s33   = {1'b0, alu_a} + {1'b0, alu_b};
                m_res = s33[31:0];
                m_flg = pack_flags(m_res == 32'd0, s33[32], m_res[31],
                                   (alu_a[31] == alu_b[31]) && (m_res[31] != alu_a[31]));
            end
            FS_SUB16: begin
                s17   = {1'b0, alu_a[15:0]} + {1'b0, ~alu_b[15:0]} + 17'd1;
                m_res = {16'h0000, s17[15:0]};
                m_flg = pack_flags(s17[15:0] == 16'd0, s17[16], s17[15],
                                   (alu_a[15] != alu_b[15]) && (s17[15] != alu_a[15]));
            end
            FS_PASSA32: begin
                m_res = alu_a;
                m_flg = pack_flags(alu_a == 32'd0, 1'b0, alu_a[31], 1'b0);
            end
            default: begin
                m_res = 32'hDEADBEEF;
                m_flg = '0;
            end
        endcase
    end

    always @(posedge clk) begin
        alu_out        <= m_res;
        alu_flags_pend <= m_flg;
        alu_flags      <= alu_flags_pend;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [IDX_W-1:0] idx, input logic [31:0] data);
        load_en   = 1'b1;
        load_idx  = idx;
        load_data = data;
        tick();
        load_en   = 1'b0;
    endtask

    task automatic issue(input logic [4:0] fs, input logic [IDX_W-1:0] a,
                         input logic [IDX_W-1:0] b, input logic [IDX_W-1:0] dst,
                         input logic wf);
        req_valid   = 1'b1;
        req_fun_sel = fs;
        req_src_a   = a;
        req_src_b   = b;
        req_dst     = dst;
        req_wf      = wf;
        tick();
        req_valid   = 1'b0;
    endtask

    task automatic wait_rsp(input string name);
        int n;
        n = 0;
        while (rsp_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s: rsp_valid timeout, got %b required 1", name, rsp_valid);
        end
    endtask

    task automatic accept();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        checks += 5;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_req_ready: got %b required 1", req_ready); end
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid: got %b required 0", rsp_valid); end
        if (alu_fun_sel !== 5'b10000) begin errors++; $display("FAIL rst_fun_sel: got %b required 10000", alu_fun_sel); end
        if (alu_a !== 32'd0 || alu_b !== 32'd0) begin errors++; $display("FAIL rst_operands: got %h/%h required 0/0", alu_a, alu_b); end
        if (status_flags !== 4'b0000 || rsp_data !== 32'd0) begin errors++; $display("FAIL rst_status: got %b/%h required 0000/0", status_flags, rsp_data); end
        $display("reset: req_ready=%b fun_sel=%b status=%b", req_ready, alu_fun_sel, status_flags);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid_op();
        do_load(3'd1, 32'h0000_0005);
        do_load(3'd2, 32'h0000_0003);
        issue(FS_ADD32, 3'd1, 3'd2, 3'd3, 1'b1);
        tick();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();
        dbg_idx = 3'd3;
        #1;
        checks += 4;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL midrst_req_ready: got %b required 1", req_ready); end
        if (dbg_data !== 32'd0) begin errors++; $display("FAIL midrst_dst: got %h required 0", dbg_data); end
        if (status_flags !== 4'b0000) begin errors++; $display("FAIL midrst_status: got %b required 0000", status_flags); end
        for (int i = 0; i < 4; i++) tick();
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL midrst_rsp_valid: got %b required 0", rsp_valid); end
        $display("reset mid-op: R3=%h status=%b rsp_valid=%b", dbg_data, status_flags, rsp_valid);
    endtask

    task automatic test_add_carry();
        do_load(3'd1, 32'hFFFF_FFFF);
        do_load(3'd2, 32'h0000_0001);
        do_load(3'd3, 32'h1234_5678);
        issue(FS_ADD32, 3'd1, 3'd2, 3'd3, 1'b1);
        checks += 8;
        if (req_ready !== 1'b0) begin errors++; $display("FAIL add_busy: got %b required 0", req_ready); end
        tick();
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL add_lat_e1: got %b required 0", rsp_valid); end
        tick();
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL add_lat_e2: got %b required 0", rsp_valid); end
        tick();
        if (rsp_valid !== 1'b1) begin errors++; $display("FAIL add_lat_e3: got %b required 1", rsp_valid); end
        if (rsp_data !== 32'h0000_0000) begin errors++; $display("FAIL add_data: got %h required 00000000", rsp_data); end
        if (rsp_flags !== 4'b1100) begin errors++; $display("FAIL add_flags: got %b required 1100", rsp_flags); end
        if (status_flags !== 4'b1100) begin errors++; $display("FAIL add_status: got %b required 1100", status_flags); end
        dbg_idx = 3'd3;
        #1;
        if (dbg_data !== 32'd0) begin errors++; $display("FAIL add_wb: got %h required 00000000", dbg_data); end
        $display("add32: data=%h flags=%b status=%b R3=%h", rsp_data, rsp_flags, status_flags, dbg_data);
        accept();
    endtask

    task automatic test_wf_gating();
        issue(FS_PASSA32, 3'd2, 3'd1, 3'd7, 1'b0);
        checks += 4;
        if (alu_wf !== 1'b0) begin errors++; $display("FAIL wf_alu_wf: got %b required 0", alu_wf); end
        wait_rsp("wf");
        if (rsp_data !== 32'h0000_0001) begin errors++; $display("FAIL wf_data: got %h required 00000001", rsp_data); end
        if (rsp_flags !== 4'b0000) begin errors++; $display("FAIL wf_flags: got %b required 0000", rsp_flags); end
        if (status_flags !== 4'b1100) begin errors++; $display("FAIL wf_status: got %b required 1100", status_flags); end
        $display("passA wf=0: data=%h flags=%b status=%b", rsp_data, rsp_flags, status_flags);
        accept();
    endtask

    task automatic test_sub16();
        do_load(3'd4, 32'd5);
        do_load(3'd5, 32'd7);
        issue(FS_SUB16, 3'd4, 3'd5, 3'd6, 1'b1);
        wait_rsp("sub16");
        checks += 4;
        if (rsp_data !== 32'h0000_FFFE) begin errors++; $display("FAIL sub16_data: got %h required 0000fffe", rsp_data); end
        if (rsp_flags !== 4'b0010) begin errors++; $display("FAIL sub16_flags: got %b required 0010", rsp_flags); end
        if (status_flags !== 4'b0010) begin errors++; $display("FAIL sub16_status: got %b required 0010", status_flags); end
        dbg_idx = 3'd6;
        #1;
        if (dbg_data !== 32'h0000_FFFE) begin errors++; $display("FAIL sub16_wb: got %h required 0000fffe", dbg_data); end
        $display("sub16: data=%h flags=%b status=%b", rsp_data, rsp_flags, status_flags);
        accept();
    endtask

    task automatic test_back_to_back();
        issue(FS_PASSA32, 3'd1, 3'd1, 3'd0, 1'b0);
        wait_rsp("bp_first");
        req_valid   = 1'b1;
        req_fun_sel = FS_PASSA32;
        req_src_a   = 3'd4;
        req_src_b   = 3'd4;
        req_dst     = 3'd2;
        req_wf      = 1'b0;
        load_en     = 1'b1;
        load_idx    = 3'd0;
        load_data   = 32'h0000_0055;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (rsp_valid !== 1'b1 || rsp_data !== 32'hFFFF_FFFF || req_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d: got v=%b d=%h rdy=%b required v=1 d=ffffffff rdy=0",
                         i, rsp_valid, rsp_data, req_ready);
            end
        end
        load_en = 1'b0;
        dbg_idx = 3'd0;
        #1;
        checks += 5;
        if (dbg_data !== 32'hFFFF_FFFF) begin errors++; $display("FAIL bp_load_ignored: got %h required ffffffff", dbg_data); end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: got rdy=%b v=%b required rdy=1 v=0", req_ready, rsp_valid);
        end
        tick();
        req_valid = 1'b0;
        if (req_ready !== 1'b0 || alu_a !== 32'd5) begin
            errors++;
            $display("FAIL bp_second_accept: got rdy=%b a=%h required rdy=0 a=00000005", req_ready, alu_a);
        end
        wait_rsp("bp_second");
        if (rsp_data !== 32'd5) begin errors++; $display("FAIL bp_second_data: got %h required 00000005", rsp_data); end
        $display("backpressure: second data=%h", rsp_data);
        accept();
        issue(5'b11111, 3'd4, 3'd5, 3'd7, 1'b0);
        wait_rsp("undef");
        if (rsp_data !== 32'hDEADBEEF) begin errors++; $display("FAIL undef_data: got %h required deadbeef", rsp_data); end
        $display("undefined funsel: data=%h", rsp_data);
        accept();
    endtask

    task automatic test_load_issue_same_cycle();
        load_en     = 1'b1;
        load_idx    = 3'd1;
        load_data   = 32'hAAAA_0000;
        issue(FS_PASSA32, 3'd1, 3'd1, 3'd5, 1'b0);
        load_en     = 1'b0;
        wait_rsp("ld_same");
        checks += 3;
        if (rsp_data !== 32'hFFFF_FFFF) begin errors++; $display("FAIL ld_same_old: got %h required ffffffff", rsp_data); end
        dbg_idx = 3'd1;
        #1;
        if (dbg_data !== 32'hAAAA_0000) begin errors++; $display("FAIL ld_same_reg: got %h required aaaa0000", dbg_data); end
        $display("load+issue: data=%h R1=%h", rsp_data, dbg_data);
        accept();
        issue(FS_PASSA32, 3'd1, 3'd1, 3'd6, 1'b0);
        wait_rsp("ld_next");
        if (rsp_data !== 32'hAAAA_0000) begin errors++; $display("FAIL ld_next_new: got %h required aaaa0000", rsp_data); end
        $display("next op: data=%h", rsp_data);
        accept();
    endtask

    initial begin
        rst_n       = 1'b0;
        req_valid   = 1'b0;
        req_fun_sel = 5'd0;
        req_src_a   = '0;
        req_src_b   = '0;
        req_dst     = '0;
        req_wf      = 1'b0;
        load_en     = 1'b0;
        load_idx    = '0;
        load_data   = '0;
        rsp_ready   = 1'b0;
        dbg_idx     = '0;
        test_reset();
        test_reset_mid_op();
        test_add_carry();
        test_wf_gating();
        test_sub16();
        test_back_to_back();
        test_load_issue_same_cycle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_issue_unit.md
Name: alu_issue_unit

Overview:
- Issue/write-back stage wrapped around the registered 32-bit ALU.
- Holds a small general-purpose register file and accepts one operation request at a time through a valid/ready handshake.
- Drives registered operands and FunSel into the ALU, waits out the ALU's result and flag latency, then writes ALUOut back to the destination register.
- Maintains the architectural status-flag register, gated by WF, and returns result and flags on a valid/ready response port.

Parameters:
- NREG, 8: number of general registers; power of two, 2..16.
- IDX_W, $clog2(NREG): register index width.

Ports:
- Clock  in  1  system clock; all state updates on rising edge.
- Reset  in  1  asynchronous, active-low reset.
- ReqValid  in  1  operation request valid.
- ReqReady  out  1  unit can accept a request.
- ReqFunSel  in  5  ALU function select, passed unchanged to the ALU.
- ReqSrcA  in  IDX_W  source register for ALU A.
- ReqSrcB  in  IDX_W  source register for ALU B.
- ReqDst  in  IDX_W  destination register.
- ReqWF  in  1  1 = update StatusFlags with this op's flags.
- LoadEn  in  1  direct register load (initialisation/test).
- LoadIdx  in  IDX_W  register written by the load.
- LoadData  in  32  load value.
- AluA  out  32  registered operand to ALU A.
- AluB  out  32  registered operand to ALU B.
- AluFunSel  out  5  registered FunSel to ALU.
- AluWF  out  1  registered copy of ReqWF.
- AluOut  in  32  ALU result.
- AluFlags  in  4  ALU flags {Z,C,N,O}.
- RspValid  out  1  response valid.
- RspReady  in  1  response accepted.
- RspData  out  32  result written back.
- RspFlags  out  4  flags produced by this op, regardless of WF.
- StatusFlags  out  4  architectural flags {Z,C,N,O}.
- DbgIdx  in  IDX_W  debug read select.
- DbgData  out  32  combinational read of register DbgIdx.

Behaviour:
- Reset (Reset=0, async):
  - State returns to IDLE.
  - All registers, AluA, AluB, RspData, RspFlags and StatusFlags clear to 0.
  - AluFunSel = 5'b10000; AluWF = 0; RspValid = 0.
  - Reset mid-operation aborts the op with no write-back.
- FSM states: IDLE, EXEC, RES, FLAG, RESP.
  - IDLE: ReqReady=1.
    - On ReqValid=1: latch AluA=R[SrcA], AluB=R[SrcB], AluFunSel, AluWF, Dst; go to EXEC.
    - If LoadEn=1 in the same cycle, the load writes first and the request reads the old value; no forwarding.
  - EXEC: operands are stable and the ALU samples them at this cycle's closing edge; go to RES.
  - RES: ALUOut is valid; capture RspData=AluOut; go to FLAG.
    - The ALU computes its flags from ALUOut one edge later.
  - FLAG:
    - Capture RspFlags=AluFlags.
    - Write R[Dst]=RspData.
    - If AluWF=1, StatusFlags=AluFlags.
    - Go to RESP.
  - RESP: RspValid=1; stay until RspReady=1, then return to IDLE.
- Latency: request accepted at edge E0, RspValid high from E3.
  - With RspReady tied high, throughput is one op per 5 cycles.
- ReqReady=0 outside IDLE. LoadEn is ignored outside IDLE.
- Operands, AluFunSel and AluWF hold their values outside IDLE acceptance, so the ALU sees stable inputs.
- Undefined FunSel is not checked: the ALU's debug value 0xDEADBEEF is written back as-is.
- Src equal to Dst is legal: operands are read at acceptance.
- DbgData reflects a write on the cycle after the write edge.

Decomposition:
- Package alu_issue_pkg:
  - state enum.
  - FunSel constants (FS_ADD32=5'b10100, FS_SUB16=5'b00110, FS_PASSA32=5'b10000, …).
  - flag bit positions Z=3, C=2, N=1, O=0.
- Sub-module alu_issue_regfile:
  - NREG×32 storage.
  - Two combinational read ports plus debug read port.
  - One write port with priority writeback > load; loads and writeback never coincide by construction.

Test Plan:
- Reset mid-op: assert Reset low during RES → RspValid=0, R[Dst] unchanged (0), StatusFlags=0, ReqReady=1 one cycle after release.
- 32-bit add with carry: load R1=0xFFFFFFFF, R2=0x00000001; req FunSel=10100, A=1, B=2, Dst=3, WF=1 → RspValid at E3, RspData=0x00000000, RspFlags=4'b1100, StatusFlags=4'b1100, DbgData(R3)=0.
- 16-bit subtract: R4=5, R5=7, FunSel=00110, Dst=6, WF=1 → RspData=0x0000FFFE, RspFlags=4'b0010.
- WF gating: after the add test, run FunSel=10000 (pass A) with R2, WF=0 → RspFlags=4'b0000, StatusFlags stays 4'b1100.
- Response backpressure: RspReady=0 for 4 cycles → RspValid, RspData and ReqReady=0 hold; second queued ReqValid accepted on the cycle after RspReady=1.
- Load/issue same cycle in IDLE: LoadEn to R1=0xAAAA0000 with req pass-A from R1 → RspData=old R1; the next op reads 0xAAAA0000.
